// File: rtl/baud_pkg.sv
// baud_pkg: rate table, divisor arithmetic and autobaud state encoding for baud_ctrl.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package baud_pkg;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 1200;
      3'd1:    return 2400;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_START,
    MEASURE,
    DONE
  } ab_state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: programmable divide-by-divisor counter emitting a one-cycle tick.
// Latency: tick registered one cycle after the count reaches divisor-1; clear zeroes count and tick.
// Backpressure: none, tick is a free-running pulse.
module tick_gen #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 clear,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 wrap;

  assign wrap = (cnt == divisor - DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// baud_ctrl: table- or autobaud-selected divisor driving the oversampling UART tick (autobaud under BAUD_CTRL_AUTOBAUD_EN).
// Latency: rate_load -> divisor/counter clear two edges later; autobaud result lands one edge after DONE.
// Backpressure: none; rate_load/auto_start are single-cycle pulses, auto_start dropped while busy.
module baud_ctrl
  import baud_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 32,
  parameter int DEFAULT_SEL = 3,
  parameter int MIN_DIV     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [2:0]           rate_sel,
  input  logic                 rate_load,
  input  logic                 auto_start,
  output logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick,
  output logic                 busy,
  output logic                 locked,
  output logic                 err
);

  localparam logic [DIV_WIDTH-1:0] DIV_TAB [8] = '{
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd0), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd1), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd2), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd3), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd4), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd5), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd6), OVERSAMPLE)),
    DIV_WIDTH'(baud_div(CLK_FREQ, baud_rate(3'd7), OVERSAMPLE))
  };

  logic                 load_pend;
  logic [2:0]           load_sel;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 div_we;
  logic                 ab_we;
  logic [DIV_WIDTH-1:0] ab_div;

  // The table load is staged one edge so the divisor and counter clear land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_pend <= 1'b0;
      load_sel  <= '0;
    end else begin
      load_pend <= rate_load;
      if (rate_load) load_sel <= rate_sel;
    end
  end

  assign div_we = load_pend | ab_we;

  always_ff @(posedge clk) begin
    if (reset)          div_q <= DIV_TAB[3'(DEFAULT_SEL)];
    else if (load_pend) div_q <= DIV_TAB[load_sel];
    else if (ab_we)     div_q <= ab_div;
  end

  assign divisor = div_q;

  tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .divisor(div_q),
    .clear  (div_we),
    .tick   (tick)
  );

`ifdef BAUD_CTRL_AUTOBAUD_EN
  localparam int OS_LOG = $clog2(OVERSAMPLE);
  localparam int MW     = DIV_WIDTH + OS_LOG;

  logic              rx_m, rx_s;
  ab_state_t         state, state_nxt;
  logic [MW-1:0]     meas, meas_nxt;
  logic [DIV_WIDTH:0] quot;
  logic              busy_q, locked_q, err_q;
  logic              locked_nxt, err_nxt, in_meas;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Extra top bit catches a rounded result that no longer fits the divisor.
  assign quot    = (DIV_WIDTH+1)'(({1'b0, meas} + (MW+1)'(OVERSAMPLE/2)) >> OS_LOG);
  assign ab_div  = quot[DIV_WIDTH-1:0];
  assign in_meas = (state == WAIT_IDLE) || (state == WAIT_START) || (state == MEASURE);

  always_comb begin
    state_nxt  = state;
    meas_nxt   = meas;
    locked_nxt = locked_q;
    err_nxt    = err_q;
    ab_we      = 1'b0;
    if (rate_load) begin
      state_nxt  = IDLE;
      locked_nxt = 1'b0;
      err_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: if (auto_start) begin
          state_nxt  = WAIT_IDLE;
          locked_nxt = 1'b0;
          err_nxt    = 1'b0;
        end
        WAIT_IDLE:  if (rx_s) state_nxt = WAIT_START;
        WAIT_START: if (!rx_s) begin
          state_nxt = MEASURE;
          meas_nxt  = MW'(1);
        end
        MEASURE: begin
          if (rx_s) begin
            state_nxt = DONE;
          end else if (meas == '1) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            meas_nxt = meas + MW'(1);
          end
        end
        DONE: begin
          state_nxt = IDLE;
          if (!quot[DIV_WIDTH] && (quot >= (DIV_WIDTH+1)'(MIN_DIV))) begin
            ab_we      = 1'b1;
            locked_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      meas     <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      meas     <= meas_nxt;
      busy_q   <= in_meas;
      locked_q <= locked_nxt;
      err_q    <= err_nxt;
    end
  end

  assign busy   = busy_q;
  assign locked = locked_q;
  assign err    = err_q;
`else
  logic unused_ab;

  assign unused_ab = ^{rx, auto_start, (MIN_DIV > 0)};
  assign ab_we     = 1'b0;
  assign ab_div    = '0;
  assign busy      = 1'b0;
  assign locked    = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
